// File: rtl/grid_keypad_scanner.sv
// grid_keypad_scanner
// Scans a 3x3 active-low matrix keypad one column at a time, assembles a
// 9-bit pressed-key frame, debounces whole frames and turns a stable single
// key into a grid code {row+1, col+1} plus a one-cycle key strobe.
// Chords and ghosting (two or more keys) block output until full release.
// Optional build macro: KEYPAD_AUTOREPEAT_EN adds a repeat strobe every
// REPEAT_FRAMES frames while the same key stays held.
module grid_keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FRAMES  = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] gp_input,
    output logic       input_key,
    output logic       key_held
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_SCANS);

    generate
        if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
            $error("grid_keypad_scanner: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_BLOCKED} state_t;

    logic [2:0]        row_meta_reg, row_sync_reg;
    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [1:0]        col_idx_reg;
    logic [8:0]        frame_reg, frame_sample;
    logic              frame_done_reg;
    logic [8:0]        prev_frame_reg;
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic              frame_stable;
    logic              is_none, is_single, is_multi;
    logic [3:0]        code_term [9];
    logic [3:0]        key_code;
    state_t            state_reg, state_next;
    logic [3:0]        gp_input_reg, gp_input_next;
    logic              input_key_reg, input_key_next;
    logic              key_held_reg, key_held_next;

    // Two-flop synchronizer; idle (pulled-up) level after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_reg <= 3'b111;
            row_sync_reg <= 3'b111;
        end else begin
            row_meta_reg <= row_in;
            row_sync_reg <= row_meta_reg;
        end
    end

    // Per-cell sampling and fixed grid code; cell index 0 (top-left) is frame bit 8.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_cell
            localparam int CELL = 8 - gi;
            assign frame_sample[gi] = (col_idx_reg == 2'(CELL % 3)) ? ~row_sync_reg[CELL / 3]
                                                                    : frame_reg[gi];
            assign code_term[gi] = frame_reg[gi] ? {2'(CELL / 3 + 1), 2'(CELL % 3 + 1)} : 4'b0000;
        end
    endgenerate

    // Column scan: drive one column per slot, sample its rows in the last slot cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_reg   <= '0;
            col_idx_reg    <= 2'd0;
            frame_reg      <= 9'd0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (slot_cnt_reg == SLOT_LAST) begin
                slot_cnt_reg   <= '0;
                frame_reg      <= frame_sample;
                col_idx_reg    <= (col_idx_reg == 2'd2) ? 2'd0 : col_idx_reg + 2'd1;
                frame_done_reg <= (col_idx_reg == 2'd2);
            end else begin
                slot_cnt_reg <= slot_cnt_reg + 1'b1;
            end
        end
    end

    assign col_out = ~(3'b001 << col_idx_reg);

    // Frame-level debounce count; the new count decides stability this frame end.
    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        if (frame_reg == prev_frame_reg) begin
            if (deb_cnt_reg != DEB_FULL) deb_cnt_next = deb_cnt_reg + 1'b1;
        end else begin
            deb_cnt_next = DEB_W'(1);
        end
    end

    // Debounce history, updated once per completed frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_frame_reg <= 9'd0;
            deb_cnt_reg    <= '0;
        end else if (frame_done_reg) begin
            prev_frame_reg <= frame_reg;
            deb_cnt_reg    <= deb_cnt_next;
        end
    end

    assign frame_stable = frame_done_reg && (deb_cnt_next == DEB_FULL);

    // Classify the frame and merge the per-cell codes (meaningful only for one key).
    always_comb begin
        key_code = 4'b0000;
        for (int i = 0; i < 9; i++) key_code = key_code | code_term[i];
        is_none   = (frame_reg == 9'd0);
        is_single = !is_none && ((frame_reg & (frame_reg - 9'd1)) == 9'd0);
        is_multi  = !is_none && !is_single;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;

    // Frames spent holding the same key since entering HELD or the last repeat.
    always_ff @(posedge clock) begin
        if (reset) rep_cnt_reg <= '0;
        else       rep_cnt_reg <= rep_cnt_next;
    end
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next state; moves only on a stable frame.
    always_comb begin
        state_next = state_reg;
        if (frame_stable) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_single)     state_next = ST_HELD;
                    else if (is_multi) state_next = ST_BLOCKED;
                end
                ST_HELD: begin
                    if (is_none)                                       state_next = ST_IDLE;
                    else if (!(is_single && key_code == gp_input_reg)) state_next = ST_BLOCKED;
                end
                ST_BLOCKED: begin
                    if (is_none) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: code, strobe and held flag, registered for clean board-level timing.
    always_comb begin
        gp_input_next  = gp_input_reg;
        input_key_next = 1'b0;
        key_held_next  = key_held_reg;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_next   = rep_cnt_reg;
`endif
        if (frame_stable) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_single) begin
                        gp_input_next  = key_code;
                        input_key_next = 1'b1;
                        key_held_next  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_next   = '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (is_single && key_code == gp_input_reg) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_cnt_reg == REP_LAST) begin
                            input_key_next = 1'b1;
                            rep_cnt_next   = '0;
                        end else begin
                            rep_cnt_next = rep_cnt_reg + 1'b1;
                        end
`endif
                    end else begin
                        gp_input_next = 4'b0000;
                        key_held_next = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_next  = '0;
`endif
                    end
                end
                default: begin
                    gp_input_next = 4'b0000;
                    key_held_next = 1'b0;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            gp_input_reg  <= 4'b0000;
            input_key_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            gp_input_reg  <= gp_input_next;
            input_key_reg <= input_key_next;
            key_held_reg  <= key_held_next;
        end
    end

    assign gp_input  = gp_input_reg;
    assign input_key = input_key_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_grid_keypad_scanner.sv
// Testbench for grid_keypad_scanner: a physical keypad model drives row_in
// from col_out; a frame-level reference model predicts strobes, code and held.
module tb_grid_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int REP      = 3;
    localparam int M_IDLE = 0, M_HELD = 1, M_BLOCKED = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] row_in;
    logic [2:0] col_out;
    logic [3:0] gp_input;
    logic       input_key;
    logic       key_held;

    logic [8:0] keys;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         gcyc = 0;
    logic       prev_key = 1'b0;

    // reference model state
    logic [8:0] hist [$];
    int         m_state;
    logic [3:0] m_gp;
    logic       m_held;
    int         m_strobe;
    int         m_rep;

    grid_keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_FRAMES(REP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .row_in(row_in),
        .col_out(col_out),
        .gp_input(gp_input),
        .input_key(input_key),
        .key_held(key_held)
    );

    always #5 clock = ~clock;

    // Keypad: a pressed cell pulls its row low while its column is driven low.
    always_comb begin
        row_in = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (keys[8 - (3 * r + c)] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_state  = M_IDLE;
        m_gp     = 4'b0000;
        m_held   = 1'b0;
        m_strobe = 0;
        m_rep    = 0;
    endtask

    // One completed frame: stable when the last DEB frames are identical.
    task automatic model_eval(input logic [8:0] v);
        int         ones;
        logic [3:0] code;
        bit         stable;
        hist.push_back(v);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_strobe = 0;
        stable = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != v) stable = 0;
        if (!stable) return;
        ones = 0;
        code = 4'b0000;
        for (int i = 0; i < 9; i++)
            if (v[i]) begin
                ones++;
                code = 4'(((8 - i) / 3 + 1) * 4 + ((8 - i) % 3 + 1));
            end
        case (m_state)
            M_IDLE: begin
                if (ones == 1) begin
                    m_state = M_HELD; m_gp = code; m_held = 1'b1; m_strobe = 1; m_rep = 0;
                end else if (ones > 1) begin
                    m_state = M_BLOCKED;
                end
            end
            M_HELD: begin
                if (ones == 1 && code == m_gp) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin
                        m_rep = 0;
                        m_strobe = 1;
                    end
`endif
                end else begin
                    m_state = (ones == 0) ? M_IDLE : M_BLOCKED;
                    m_gp = 4'b0000; m_held = 1'b0; m_rep = 0;
                end
            end
            default: begin
                if (ones == 0) m_state = M_IDLE;
            end
        endcase
    endtask

    // Runs one 12-cycle frame starting at the negedge of its first cycle.
    task automatic run_frame(input logic [8:0] vec, input int bcell, output int seen);
        logic [8:0] cap;
        logic [2:0] exp_col;
        seen = 0;
        cap  = 9'd0;
        keys = vec;
        for (int k = 0; k < 12; k++) begin
            if (bcell >= 0 && gcyc % 5 == 0) keys[bcell] = ~keys[bcell];
            gcyc++;
            if (k % 4 == 1)
                for (int r = 0; r < 3; r++) cap[8 - (3 * r + k / 4)] = keys[8 - (3 * r + k / 4)];
            exp_col = ~(3'b001 << (k / 4));
            check("col_out", col_out, exp_col);
            if (input_key) begin
                seen++;
                check("strobe_gap", prev_key, 0);
                check("strobe_code", gp_input, m_gp);
            end
            prev_key = input_key;
            if (k == 11) begin
                check("strobes", seen, m_strobe);
                check("gp_input", gp_input, m_gp);
                check("key_held", key_held, m_held);
            end
            @(negedge clock);
        end
        model_eval(cap);
    endtask

    task automatic txn(input string name, input logic [8:0] vec, input int frames,
                       input int bcell, output int total);
        int seen;
        total = 0;
        for (int f = 0; f < frames; f++) begin
            run_frame(vec, (f < 3) ? bcell : -1, seen);
            total += seen;
        end
        $display("txn %-12s keys=%b frames=%0d strobes=%0d gp=%b held=%b",
                 name, vec, frames, total, gp_input, key_held);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("rst_gp", gp_input, 0);
            check("rst_held", key_held, 0);
            check("rst_key", input_key, 0);
            check("rst_col", col_out, 3'b110);
        end
        reset    = 1'b0;
        prev_key = 1'b0;
        model_reset();
        $display("txn %-12s cycles=%0d gp=%b held=%b", "reset", n, gp_input, key_held);
    endtask

    initial begin
        int tot;
        int kind;
        int a, b;
        logic [8:0] v;
        reset = 1'b1;
        keys  = 9'd0;
        model_reset();
        do_reset(20);

        txn("r0c0", 9'b1_0000_0000, 10, -1, tot);
        check("r0c0_gp", gp_input, 4'b0101);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("r0c0_strobes", tot, 1);
`endif
        txn("release", 9'd0, 3, -1, tot);
        check("release_gp", gp_input, 0);
        txn("r2c2", 9'b0_0000_0001, 6, -1, tot);
        check("r2c2_gp", gp_input, 4'b1111);
        txn("release", 9'd0, 3, -1, tot);
        txn("r1c0", 9'b0_0010_0000, 6, -1, tot);
        check("r1c0_gp", gp_input, 4'b1001);
        txn("release", 9'd0, 3, -1, tot);
        txn("r0c2", 9'b0_0100_0000, 6, -1, tot);
        check("r0c2_gp", gp_input, 4'b0111);
        txn("release", 9'd0, 3, -1, tot);
        txn("bounce_r1c1", 9'b0_0001_0000, 8, 4, tot);
        check("bounce_gp", gp_input, 4'b1010);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("bounce_strobes", tot, 1);
`endif
        txn("release", 9'd0, 3, -1, tot);
        txn("chord", 9'b0_1000_0100, 5, -1, tot);
        check("chord_gp", gp_input, 0);
        check("chord_strobes", tot, 0);
        txn("release", 9'd0, 3, -1, tot);
        txn("r1c2", 9'b0_0000_1000, 5, -1, tot);
        check("r1c2_gp", gp_input, 4'b1011);
        txn("release", 9'd0, 3, -1, tot);
        txn("r0c0", 9'b1_0000_0000, 5, -1, tot);
        txn("add_r1c1", 9'b1_0001_0000, 4, -1, tot);
        check("add_gp", gp_input, 0);
        check("add_held", key_held, 0);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("add_strobes", tot, 0);
`endif
        txn("release", 9'd0, 3, -1, tot);
        txn("r2c1", 9'b0_0000_0010, 5, -1, tot);
        check("r2c1_held", key_held, 1);
        do_reset(3);
        txn("r2c1_again", 9'b0_0000_0010, 6, -1, tot);
        check("r2c1_gp", gp_input, 4'b1110);
        check("r2c1_restrobe", (tot > 0) ? 1 : 0, 1);
        txn("r0c0_long", 9'b1_0000_0000, 12, -1, tot);
        txn("release", 9'd0, 3, -1, tot);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 8);
            b = (a + $urandom_range(1, 8)) % 9;
            v = 9'd0;
            if (kind <= 1) begin
                txn("rnd_release", v, $urandom_range(1, 3), -1, tot);
            end else if (kind <= 5) begin
                v[a] = 1'b1;
                txn("rnd_single", v, $urandom_range(2, 8), -1, tot);
            end else if (kind <= 7) begin
                v[a] = 1'b1;
                v[b] = 1'b1;
                txn("rnd_multi", v, $urandom_range(2, 5), -1, tot);
            end else if (kind == 8) begin
                v[a] = 1'b1;
                txn("rnd_bounce", v, $urandom_range(4, 7), a, tot);
            end else begin
                do_reset($urandom_range(1, 5));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
